mem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single 16x8 `Ram` between the `Processor` (master 0) and a second memory master such as a program loader or debug port (master 1). It sits between the masters and `Ram`, drives the `Ram`'s separate read and write ports from a registered command, and returns read data with a valid strobe. One `Ram` access completes every two cycles at most.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master Ram arbiter.
package mem_arb_pkg;

  localparam int AW_DEFAULT = 4;
  localparam int DW_DEFAULT = 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to the master that did not win last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = M0;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = ~last;
      default: winner = M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one Ram between two masters; one access per
// IDLE/BUSY pair, all Ram-facing and master-facing outputs come from flops.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] r_addr,
  output logic          r_enable,
  input  logic [DW-1:0] r_data,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          w_enable
);

  logic [1:0]    req_vec;
  logic [1:0]    we_vec;
  logic [AW-1:0] addr_vec  [2];
  logic [DW-1:0] wdata_vec [2];

  assign req_vec       = {m1_req, m0_req};
  assign we_vec        = {m1_we, m0_we};
  assign addr_vec[0]   = m0_addr;
  assign addr_vec[1]   = m1_addr;
  assign wdata_vec[0]  = m0_wdata;
  assign wdata_vec[1]  = m1_wdata;

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          cur_q, cur_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q [2];
  logic [DW-1:0] rdata_d [2];
  logic [AW-1:0] r_addr_q, r_addr_d;
  logic          r_en_q, r_en_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic          w_en_q, w_en_d;

  logic          pick_valid;
  logic          pick_winner;

  rr_pick2 u_pick (
    .req    (req_vec),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cur_d    = cur_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    r_addr_d = r_addr_q;
    r_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d             = BUSY;
          cur_d               = pick_winner;
          last_d              = pick_winner;
          gnt_d[pick_winner]  = 1'b1;
          // Only the port being used is reloaded; the other keeps its last values.
          if (we_vec[pick_winner]) begin
            w_en_d   = 1'b1;
            w_addr_d = addr_vec[pick_winner];
            w_data_d = wdata_vec[pick_winner];
          end else begin
            r_en_d   = 1'b1;
            r_addr_d = addr_vec[pick_winner];
          end
        end
      end
      BUSY: begin
        state_d = IDLE;
        if (r_en_q) begin
          rdata_d[cur_q]  = r_data;
          rvalid_d[cur_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= M1;
      cur_q      <= M0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      r_addr_q   <= '0;
      r_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_en_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
      r_addr_q   <= r_addr_d;
      r_en_q     <= r_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_en_q     <= w_en_d;
    end
  end

  assign m0_gnt    = gnt_q[M0];
  assign m1_gnt    = gnt_q[M1];
  assign m0_rvalid = rvalid_q[M0];
  assign m1_rvalid = rvalid_q[M1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign r_addr    = r_addr_q;
  assign r_enable  = r_en_q;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign w_enable  = w_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model,
// per-cycle output comparison, directed scenarios and random traffic.
module tb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] r_addr, w_addr;
  logic          r_enable, w_enable;
  logic [DW-1:0] r_data, w_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .r_addr(r_addr), .r_enable(r_enable), .r_data(r_data),
    .w_addr(w_addr), .w_data(w_data), .w_enable(w_enable)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 4) return 8'h01;
    return 8'((i * 29) ^ 8'h5A);
  endfunction

  // Ram model: asynchronous read, write lands at the edge closing a write cycle.
  logic [DW-1:0] ram [16];
  assign r_data = ram[r_addr];
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (w_enable) ram[w_addr] = w_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an access granted at sampling edge k occupies cycle k+1,
  // completes at edge k+1, and the next grant may only happen at edge k+2.
  logic [DW-1:0] mdl_mem [16];
  logic [1:0]    exp_gnt, exp_rvalid;
  logic [DW-1:0] exp_rdata [2];
  logic          exp_r_en, exp_w_en;
  logic [AW-1:0] exp_r_addr, exp_w_addr;
  logic [DW-1:0] exp_w_data;
  bit            last_m;
  int            cyc, last_grant_cyc;
  bit            fl_m, fl_we;
  logic [AW-1:0] fl_addr;
  logic [DW-1:0] fl_wdata;

  task automatic model_reset();
    exp_gnt = '0; exp_rvalid = '0; exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_r_en = 1'b0; exp_w_en = 1'b0; exp_r_addr = '0; exp_w_addr = '0; exp_w_data = '0;
    last_m = 1'b1; cyc = 0; last_grant_cyc = -100;
  endtask

  initial begin
    bit w;
    for (int i = 0; i < 16; i++) mdl_mem[i] = init_val(i);
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        cyc++;
        exp_gnt = '0; exp_rvalid = '0; exp_r_en = 1'b0; exp_w_en = 1'b0;
        if (cyc == last_grant_cyc + 1) begin
          if (fl_we) mdl_mem[fl_addr] = fl_wdata;
          else begin
            exp_rvalid[fl_m] = 1'b1;
            exp_rdata[fl_m]  = mdl_mem[fl_addr];
          end
        end
        if (cyc >= last_grant_cyc + 2 && (m0_req || m1_req)) begin
          w = (m0_req && m1_req) ? !last_m : m1_req;
          last_m = w;
          last_grant_cyc = cyc;
          fl_m = w;
          fl_we    = w ? m1_we : m0_we;
          fl_addr  = w ? m1_addr : m0_addr;
          fl_wdata = w ? m1_wdata : m0_wdata;
          exp_gnt[w] = 1'b1;
          if (fl_we) begin
            exp_w_en = 1'b1; exp_w_addr = fl_addr; exp_w_data = fl_wdata;
          end else begin
            exp_r_en = 1'b1; exp_r_addr = fl_addr;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, exp_gnt});
      chk("rvalid", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, exp_rvalid});
      chk("m0_rdata", {24'd0, m0_rdata}, {24'd0, exp_rdata[0]});
      chk("m1_rdata", {24'd0, m1_rdata}, {24'd0, exp_rdata[1]});
      chk("ram_enables", {30'd0, r_enable, w_enable}, {30'd0, exp_r_en, exp_w_en});
      chk("r_addr", {28'd0, r_addr}, {28'd0, exp_r_addr});
      chk("w_port", {20'd0, w_addr, w_data}, {20'd0, exp_w_addr, exp_w_data});
      chk("enables_exclusive", {31'd0, r_enable & w_enable}, 32'd0);
    end
  end

  task automatic drive(input bit m, input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m) begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic txn(input bit m, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    @(negedge clk); #1; drive(m, 1'b1, we, a, d);
    @(negedge clk);
    chk("txn_gnt", {30'd0, m1_gnt, m0_gnt}, m ? 32'd2 : 32'd1);
    #1; drive(m, 1'b0, 1'b0, a, d);
    @(negedge clk);
    chk("txn_rvalid", {30'd0, m1_rvalid, m0_rvalid}, we ? 32'd0 : (m ? 32'd2 : 32'd1));
    if (!we) chk("txn_rdata", {24'd0, m ? m1_rdata : m0_rdata}, {24'd0, exp_rd});
  endtask

  initial begin
    int gnt_at[$];
    int gnt_m[$];
    int g_cnt, v_cnt;

    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 4'd5, 8'h77);
    @(posedge clk); cmp_en = 1'b1;

    // Reset held with requests pending: nothing may be granted.
    repeat (3) begin
      @(negedge clk);
      chk("reset_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("reset_enables", {30'd0, r_enable, w_enable}, 32'd0);
      chk("reset_rdata", {16'd0, m1_rdata, m0_rdata}, 32'd0);
    end
    #1; drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00); drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;

    txn(1'b0, 1'b0, 4'd4, 8'h00, 8'h01);
    txn(1'b1, 1'b1, 4'd6, 8'hA5, 8'h00);
    chk("ram6_after_write", {24'd0, ram[6]}, 32'h0000_00A5);
    txn(1'b0, 1'b0, 4'd6, 8'h00, 8'hA5);

    // Tie straight after reset, then continuous contention.
    @(negedge clk); #1; rst = 1'b0;
    @(negedge clk); #1; rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m0_gnt) begin gnt_at.push_back(i); gnt_m.push_back(0); end
      if (m1_gnt) begin gnt_at.push_back(i); gnt_m.push_back(1); end
    end
    #1; drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00); drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("contention_count", gnt_m.size(), 32'd4);
    for (int k = 0; k < gnt_m.size() && k < 4; k++) begin
      chk("contention_winner", gnt_m[k], k % 2);
      chk("contention_spacing", gnt_at[k], 2 * k);
    end

    // Reset in the middle of an m1 read.
    @(negedge clk); #1; drive(1'b1, 1'b1, 1'b0, 4'd6, 8'h00);
    @(posedge clk); #1;
    chk("midbusy_gnt_before", {31'd0, m1_gnt}, 32'd1);
    #1; rst = 1'b0; drive(1'b1, 1'b0, 1'b0, 4'd6, 8'h00);
    @(negedge clk);
    chk("midbusy_drop", {29'd0, m1_gnt, r_enable, m1_rvalid}, 32'd0);
    #1; rst = 1'b1;
    v_cnt = 0;
    repeat (3) begin @(negedge clk); if (m1_rvalid) v_cnt++; end
    chk("midbusy_no_rvalid", v_cnt, 32'd0);
    #1; drive(1'b0, 1'b1, 1'b0, 4'd7, 8'h00); drive(1'b1, 1'b1, 1'b0, 4'd8, 8'h00);
    @(negedge clk);
    chk("post_reset_tie", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    #1; drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00); drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);

    // Held read request for six sampling edges.
    @(negedge clk); #1; drive(1'b0, 1'b1, 1'b0, 4'd4, 8'h00);
    g_cnt = 0; v_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (m0_gnt) g_cnt++;
      if (m0_rvalid) begin
        v_cnt++;
        chk("held_rdata", {24'd0, m0_rdata}, 32'h0000_0001);
      end
      if (i == 5) begin #1; drive(1'b0, 1'b0, 1'b0, 4'd4, 8'h00); end
    end
    chk("held_grants", g_cnt, 32'd3);
    chk("held_rvalids", v_cnt, 32'd3);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      drive(1'b0, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
            AW'($urandom), DW'($urandom));
      drive(1'b1, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
            AW'($urandom), DW'($urandom));
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
    end
    @(negedge clk); #1; rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00); drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
